// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep harness.
// Bit-order constants tie drive/sample bits to the benchmark netlist pin names.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        EMIT
    } state_t;

    localparam int N_IN_DEF  = 4;
    localparam int N_OUT_DEF = 5;

    localparam int DRIVE_IN1_BIT = 0;
    localparam int DRIVE_IN2_BIT = 1;
    localparam int DRIVE_IN3_BIT = 2;
    localparam int DRIVE_IN4_BIT = 3;

    localparam int SAMPLE_N7_BIT  = 0;
    localparam int SAMPLE_N9_BIT  = 1;
    localparam int SAMPLE_N11_BIT = 2;
    localparam int SAMPLE_N13_BIT = 3;
    localparam int SAMPLE_N15_BIT = 4;

    function automatic int tt_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_pattern_cnt.sv
// Pattern counter with a settle counter that waits LAT cycles per pattern
// before flagging the capture cycle.
module tt_pattern_cnt
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    output logic [N_IN-1:0] cnt,
    output logic            capture_en,
    output logic            last
);

    localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    logic [WW-1:0] wcnt;

    assign capture_en = en && (wcnt == WW'(LAT));
    assign last       = capture_en && (cnt == {N_IN{1'b1}});

    // The final pattern is left on cnt so the netlist keeps seeing it after the sweep.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            wcnt <= '0;
        end else if (en) begin
            if (capture_en) begin
                wcnt <= '0;
                if (!last)
                    cnt <= cnt + 1'b1;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sweep.sv
// Drives every input pattern into a combinational netlist, collects one truth-table
// word per netlist output and streams the words out over valid/ready.
module truth_table_sweep
    import tt_sweep_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int LAT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic [N_IN-1:0]            drive_o,
    input  logic [N_OUT-1:0]           sample_i,
    output logic                       tt_valid,
    input  logic                       tt_ready,
    output logic [$clog2(N_OUT)-1:0]   tt_index,
    output logic [tt_w(N_IN)-1:0]      tt_data,
    output logic                       done
);

    localparam int TT_W = tt_w(N_IN);
    localparam int IW   = $clog2(N_OUT);

    state_t            state;
    logic [TT_W-1:0]   tt_reg   [N_OUT];
    logic [TT_W-1:0]   cap_next [N_OUT];
    logic [N_IN-1:0]   cnt;
    logic              capture_en;
    logic              last;
    logic              clear;
    logic [IW-1:0]     idx_next;

    assign clear    = (state == IDLE) && start;
    assign drive_o  = cnt;
    assign idx_next = tt_index + 1'b1;

    tt_pattern_cnt #(
        .N_IN (N_IN),
        .LAT  (LAT)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .en         (state == DRIVE),
        .cnt        (cnt),
        .capture_en (capture_en),
        .last       (last)
    );

    // Capture array including this cycle's sample, so word 0 can be loaded on the last capture.
    always_comb begin
        cap_next = tt_reg;
        if (capture_en) begin
            for (int j = 0; j < N_OUT; j++)
                cap_next[j][cnt] = sample_i[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tt_valid <= 1'b0;
            tt_index <= '0;
            tt_data  <= '0;
            done     <= 1'b0;
            for (int j = 0; j < N_OUT; j++)
                tt_reg[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DRIVE;
                        busy  <= 1'b1;
                        for (int j = 0; j < N_OUT; j++)
                            tt_reg[j] <= '0;
                    end
                end
                DRIVE: begin
                    tt_reg <= cap_next;
                    if (last) begin
                        state    <= EMIT;
                        tt_valid <= 1'b1;
                        tt_index <= '0;
                        tt_data  <= cap_next[0];
                    end
                end
                EMIT: begin
                    if (tt_ready) begin
                        if (tt_index == IW'(N_OUT - 1)) begin
                            state    <= IDLE;
                            tt_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            tt_index <= idx_next;
                            tt_data  <= tt_reg[idx_next];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Sequential harness stage that sits directly around a combinational benchmark netlist (4 inputs, 5 outputs). It drives every input pattern into the netlist upstream and captures each output downstream. It assembles one truth-table word per output and emits the words over a valid/ready stream for the synthesis-comparison flow. Pattern bit order matches the netlist input order, so the emitted words are directly comparable to reference truth tables.

## Interface
- N_IN, 4: number of netlist inputs; truth-table width TT_W = 2**N_IN
- N_OUT, 5: number of netlist outputs captured
- LAT, 0: extra netlist latency in cycles, for registered variants; 0 = purely combinational
- clk  input  1  clock; single clock domain
- rst  input  1  reset; synchronous, active-high
- start  input  1  begin sweep; sampled only in IDLE
- busy  output  1  high from the cycle after an accepted start until the cycle after the final stream handshake
- drive_o  output  N_IN  registered pattern to the netlist; bit 0 = in1, bit 3 = in4
- sample_i  input  N_OUT  netlist outputs; bit 0 = n7, bit 1 = n9, bit 2 = n11, bit 3 = n13, bit 4 = n15
- tt_valid  output  1  truth-table word available
- tt_ready  input  1  consumer accepts the word
- tt_index  output  $clog2(N_OUT)  output number of the current word
- tt_data  output  TT_W  truth table; bit k = output value for pattern drive_o==k
- done  output  1  one-cycle pulse when the sweep completes

## Operation
- States: IDLE, DRIVE, EMIT.
- IDLE:
  - on start, clear pattern counter cnt, wait counter wcnt and all capture registers; go to DRIVE.
  - start in any other state is ignored.
- DRIVE:
  - drive_o = cnt; wcnt counts 0..LAT.
  - in the cycle where wcnt==LAT, capture sample_i[j] into tt_reg[j][cnt] for every j.
  - if cnt == TT_W-1, go to EMIT with j=0; else cnt++ and wcnt=0.
- EMIT:
  - tt_valid=1, tt_index=j, tt_data=tt_reg[j].
  - on tt_valid&tt_ready: j++; after j==N_OUT-1, go to IDLE and assert done for one cycle.
- While tt_valid && !tt_ready, tt_index and tt_data are held stable.
- tt_valid never drops without a handshake.
- drive_o holds its last pattern (TT_W-1) through EMIT and IDLE until the next start.
- Reset values: drive_o=0, tt_valid=0, tt_index=0, tt_data=0, busy=0, done=0, state=IDLE, all capture registers 0.
- Reset mid-sweep or mid-EMIT aborts immediately: no done pulse, the partial word is discarded, and tt_valid falls in the cycle after rst is sampled.
- start coincident with rst: rst wins.

## Timing
- start sampled high in cycle 0 → DRIVE from cycle 1, busy=1 from cycle 1.
- Pattern k is driven from cycle 1+k(LAT+1) and captured at cycle 1+k(LAT+1)+LAT.
- EMIT is entered at cycle E = 1+TT_W(LAT+1); with LAT=0, E=17.
- With tt_ready held high, words 0..N_OUT-1 transfer in cycles E..E+N_OUT-1.
- done=1 and busy=0 in cycle E+N_OUT; a new start is accepted in that cycle.
- Backpressure only stretches EMIT; capture timing is unaffected.

## Structure
- Package tt_sweep_pkg:
  - state enum (IDLE, DRIVE, EMIT)
  - function tt_w(n_in) = 2**n_in
  - bit-order constants for drive_o and sample_i
- One sub-module, tt_pattern_cnt: pattern counter plus LAT wait counter, with outputs cnt, capture_en and last.
- The top level holds the FSM, the capture array and the stream output register.

## Test plan
- **Nominal sweep** (LAT=0, netlist attached, tt_ready=1): start at cycle 0 → words in cycles 17..21 are index 0..4 with data 0x8000, 0x8080, 0xA000, 0xC000, 0x8800; done pulses at cycle 22.
- **Backpressure**: tt_ready low for 3 cycles on word 2 → word 2 (0xA000) is held stable throughout; no word is lost or duplicated; done is delayed by 3 cycles to cycle 25.
- **LAT=2 with a 2-stage registered netlist**: the same five words result; EMIT is entered at cycle 49.
- **Reset mid-sweep**: rst at cycle 8 → state IDLE and tt_valid=0 from the next cycle, no done; a fresh start yields correct words.
- **start while busy**: extra start pulses during DRIVE and EMIT are ignored, so exactly one sweep and one done pulse occur.
- **Back-to-back**: start in the done cycle → second sweep begins next cycle and produces identical words.
